// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package riscv_pkg;

  // addi x0, x0, 0: shown on the decode side whenever nothing valid is presented
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: power-of-two depth, flush has priority over push/pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is only accepted when the head leaves in the same cycle
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Next pointers and occupancy; flush empties the buffer outright
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, buffers words for decode.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter int            DW         = 32,
  parameter int            ADDENT     = 4,
  parameter logic [DW-1:0] RESET_PC   = '0,
  parameter int            FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  output logic          fetch_valid_o,
  input  logic          fetch_ready_i,
  output logic [DW-1:0] pc_d_o,
  output logic [DW-1:0] instr_d_o
);

  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] ALIGN_MASK = ~DW'(3);

  fetch_state_e    state_q, state_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   out_pc_q, out_pc_d;
  logic [2*DW-1:0] fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            fifo_push, fifo_pop;
  logic            issue;

  // Request only when a buffer slot is guaranteed for the response
  assign issue       = rst_i && (state_q == REQ) && (fifo_count < DEPTH_C);
  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  assign fetch_valid_o = rst_i && !fifo_empty;
  assign pc_d_o        = fetch_valid_o ? fifo_head[2*DW-1:DW] : '0;
  assign instr_d_o     = fetch_valid_o ? fifo_head[DW-1:0] : DW'(NOP_INSTR);

  // A redirect kills both the returning word and the decode-side handshake
  assign fifo_pop  = fetch_valid_o && fetch_ready_i;
  assign fifo_push = (state_q == WAIT) && imem_rvalid_i && !redirect_i && (!fifo_full || fifo_pop);

  fetch_fifo #(
    .W     (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .data_i  ({out_pc_q, imem_rdata_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next FSM state and PC; a redirect overrides whatever the handshake would have done
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_pc_d = out_pc_q;
    case (state_q)
      REQ: begin
        if (issue && imem_gnt_i) begin
          out_pc_d = pc_q;
          pc_d     = pc_q + DW'(ADDENT);
          state_d  = WAIT;
        end
      end
      WAIT:    if (imem_rvalid_i) state_d = REQ;
      DROP:    if (imem_rvalid_i) state_d = REQ;
      default: state_d = REQ;
    endcase
    if (redirect_i) begin
      pc_d = redirect_pc_i & ALIGN_MASK;
      case (state_q)
        REQ:     state_d = (issue && imem_gnt_i) ? DROP : REQ;
        WAIT,
        DROP:    state_d = imem_rvalid_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  // FSM, PC and in-flight PC registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Scoreboard bench for riscv_fetch_stage: memory responder + model drive, monitor checks decode side.
`timescale 1ns/1ps
module tb_riscv_fetch_stage;
  import riscv_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] pc_d_o;
  logic [31:0] instr_d_o;

  riscv_fetch_stage #(
    .DW         (32),
    .ADDENT     (4),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .pc_d_o        (pc_d_o),
    .instr_d_o     (instr_d_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entries decode should see, in program order
  fetch_entry_t exp_q[$];
  fetch_entry_t pend_entry;
  bit           pend_valid = 0;
  logic [31:0]  model_pc = RESET_PC;
  logic [31:0]  req_pc = '0;
  logic [31:0]  mem_addr = '0;
  bit           dut_busy = 0;
  bit           mem_busy = 0;
  bit           cancelled = 0;
  int           lat_cnt = 0;
  int           lat_min = 0;
  int           lat_max = 0;
  int           cyc = 0;
  int           first_gnt_cyc = -1;
  int           first_valid_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; entered at posedge+1, returns at the next posedge+1
  task automatic step(input bit rst, input bit g, input bit rdy, input bit redir,
                      input logic [31:0] rpc);
    bit exp_req;
    cyc++;
    if (pend_valid) begin
      exp_q.push_back(pend_entry);
      pend_valid = 0;
    end
    rst_i         = rst;
    imem_gnt_i    = g && !mem_busy;
    imem_rvalid_i = mem_busy && (lat_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word(mem_addr) : $urandom();
    fetch_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(negedge clk_i);
    exp_req = rst && !dut_busy && (exp_q.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr_o, model_pc);
    if (!rst) begin
      dut_busy   = 0;
      cancelled  = 0;
      pend_valid = 0;
      model_pc   = RESET_PC;
      if (imem_rvalid_i) mem_busy = 0;
      else if (mem_busy) lat_cnt--;
    end else begin
      if (imem_rvalid_i) begin
        mem_busy = 0;
        if (dut_busy) begin
          dut_busy = 0;
          if (!cancelled && !redir) begin
            pend_entry.pc    = req_pc;
            pend_entry.instr = mem_word(req_pc);
            pend_valid       = 1;
          end
        end
      end else if (mem_busy) begin
        lat_cnt--;
        if (redir) cancelled = 1;
      end
      if (imem_req_o && imem_gnt_i) begin
        mem_busy  = 1;
        dut_busy  = 1;
        mem_addr  = imem_addr_o;
        req_pc    = model_pc;
        cancelled = redir;
        lat_cnt   = $urandom_range(lat_max, lat_min);
        model_pc  = model_pc + 32'd4;
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
      if (redir) model_pc = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0);
  endtask

  // Monitor: compares the decode-side outputs against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
        chk("rst_pc", pc_d_o, 32'd0);
        chk("rst_instr", instr_d_o, NOP_INSTR);
        exp_q.delete();
      end else begin
        chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
          chk("pc_d", pc_d_o, exp_q[0].pc);
          chk("instr_d", instr_d_o, exp_q[0].instr);
        end else begin
          chk("idle_pc", pc_d_o, 32'd0);
          chk("idle_instr", instr_d_o, NOP_INSTR);
        end
        if (fetch_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (redirect_i) begin
          exp_q.delete();
        end else if (fetch_valid_o && fetch_ready_i && exp_q.size() != 0) begin
          $display("cycle %0d: decode took pc=%08h instr=%08h", cyc, pc_d_o, instr_d_o);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    int r;
    rst_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; fetch_ready_i = 0;
    @(posedge clk_i);
    #1;

    // Streaming with a zero-wait memory; first word visible 2 cycles after its grant
    do_reset(2);
    first_gnt_cyc = -1;
    first_valid_cyc = -1;
    repeat (12) step(1, 1, 1, 0, '0);
    chk("first_valid_latency", first_valid_cyc - first_gnt_cyc, 32'd2);

    // Decode stalled: buffer fills, requests stop, then drains in order
    do_reset(1);
    repeat (10) step(1, 1, 0, 0, '0);
    repeat (10) step(1, 1, 1, 0, '0);

    // Redirect while waiting on a slow response
    do_reset(1);
    lat_min = 3; lat_max = 3;
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 1, 32'h0000_0088);
    lat_min = 0; lat_max = 0;
    repeat (10) step(1, 1, 1, 0, '0);

    // Redirect coinciding with the response
    do_reset(1);
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 1, 32'h0000_0040);
    repeat (6) step(1, 1, 1, 0, '0);

    // Grant withheld: address holds, then a redirect moves it
    do_reset(1);
    step(1, 1, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    repeat (4) step(1, 0, 1, 0, '0);
    step(1, 0, 1, 1, 32'h0000_007C);
    repeat (6) step(1, 1, 1, 0, '0);

    // Misaligned target, then reset mid-stream
    step(1, 1, 1, 1, 32'h0000_008B);
    repeat (6) step(1, 1, 1, 0, '0);
    do_reset(1);
    repeat (8) step(1, 1, 1, 0, '0);

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    repeat (2000) begin
      r = $urandom_range(0, 99);
      if (r == 0) do_reset($urandom_range(1, 2));
      else step(1, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 6, $urandom() & 32'h0000_0FFF);
    end
    repeat (4) step(1, 1, 1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
Instruction-fetch stage of the 3-stage pipelined core.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents {pc, instr} to the decode stage with a valid/ready handshake.
- Handles branch/jump redirects from execute: flushes buffered and in-flight fetches.

Parameters:
DW, 32, data/address width
ADDENT, 4, PC increment per fetched instruction
RESET_PC, 32'h0000_0000, PC after reset
FIFO_DEPTH, 2, entries in the fetch buffer (power of two, >= 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  DW  fetch address (current PC)
imem_gnt_i  in  1  memory accepted the request this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  DW  instruction word
redirect_i  in  1  branch/jump taken; flush and restart
redirect_pc_i  in  DW  target PC
fetch_valid_o  out  1  decode-side entry valid
fetch_ready_i  in  1  decode accepts the entry
pc_d_o  out  DW  PC of presented instruction
instr_d_o  out  DW  presented instruction

Behaviour:
- Reset (rst_i==0 at a rising edge):
  - pc_q=RESET_PC, state=REQ, FIFO empty.
  - Outputs while rst_i low: imem_req_o=0, fetch_valid_o=0, pc_d_o=0, instr_d_o=32'h00000013 (NOP).
- FSM states and transitions:
  - REQ: imem_req_o = (count < FIFO_DEPTH); imem_addr_o=pc_q.
    - On req && gnt: record out_pc=pc_q, pc_q += ADDENT (mod 2^DW), go to WAIT.
    - Without gnt: stay in REQ; addr is held stable.
  - WAIT: imem_req_o=0.
    - On rvalid: push {out_pc, rdata}, go to REQ.
  - DROP: imem_req_o=0.
    - On rvalid: discard the data, go to REQ.
- At most one outstanding request.
- Throughput: one instruction per 2 cycles with a zero-wait memory.
- Output side: fetch_valid_o = !empty; pc_d_o/instr_d_o = FIFO head.
  - When empty: pc_d_o=0, instr_d_o=NOP.
  - Pop when fetch_valid_o && fetch_ready_i.
  - Push and pop in the same cycle are both honoured.
  - A push never occurs when full, because issue is gated on count < FIFO_DEPTH.
- Latency: request granted in cycle N, rvalid in N+1 → fetch_valid_o high in N+2.
- Redirect has priority over every other event:
  - FIFO cleared that cycle; any same-cycle pop or push is ignored. fetch_valid_o=0 the next cycle.
  - pc_q <= {redirect_pc_i[DW-1:2], 2'b00} (misaligned low bits forced to zero).
- Next state on redirect:
  - REQ without gnt: REQ, addr changes to the new PC (the only allowed addr change while req && !gnt).
  - REQ with gnt: DROP (the granted old-PC fetch is in flight).
  - WAIT without rvalid: DROP.
  - WAIT with rvalid: REQ, the data is discarded.
  - DROP without rvalid: stays DROP.
  - DROP with rvalid: REQ.
- A reset asserted mid-operation aborts everything. An in-flight response arriving after reset is ignored, because state is REQ and not WAIT.

Decomposition:
- riscv_pkg holds:
  - NOP_INSTR = 32'h00000013
  - typedef enum logic [1:0] fetch_state_e {REQ, WAIT, DROP}
  - typedef struct packed fetch_entry_t {pc, instr}
- Sub-module fetch_fifo: parameterised depth, synchronous active-low reset, flush input, push/pop, count/full/empty.

Test Plan:
- Reset release, memory gnt=1 always, rvalid one cycle later, ready=1 → PCs 0,4,8,… presented; first fetch_valid_o exactly 2 cycles after first grant.
- fetch_ready_i=0 → FIFO fills to 2 entries (PC 0,4), then imem_req_o drops. Ready=1 → entries drain in order and fetching resumes at PC 8.
- Redirect to 32'h0000_0088 while in WAIT (rvalid delayed 3 cycles) → stale word discarded, fetch_valid_o=0 next cycle, next req addr=0x88, first presented pc_d_o=0x88.
- Redirect in the same cycle as rvalid in WAIT → data dropped, no DROP state, next req addr = target.
- gnt withheld 4 cycles → imem_addr_o stable at 0x4. Redirect during the stall to 0x7C → addr switches to 0x7C the next cycle.
- Redirect target 0x8B → fetch addr 0x88. rst_i pulsed low mid-stream → all outputs return to their reset values and fetch restarts at RESET_PC.
